// File: rtl/yuv2rgb_csc.sv
// yuv2rgb_csc: full-range BT.601 YUV444 to RGB888 converter, 3-stage pipeline,
// with a conversion enable that only changes at the active vsync edge.
module yuv2rgb_csc #(
   parameter int    DATA_DEPTH  = 8,
   parameter string HS_POLARITY = "NEGATIVE",
   parameter string VS_POLARITY = "NEGATIVE",
   parameter int    COEF_RV     = 359,
   parameter int    COEF_GU     = 88,
   parameter int    COEF_GV     = 183,
   parameter int    COEF_BU     = 454
) (
   input  logic                  i_arst,
   input  logic                  i_pclk,
   input  logic                  i_csc_en,
   input  logic                  i_vsync,
   input  logic                  i_hsync,
   input  logic                  i_de,
   input  logic [DATA_DEPTH-1:0] i_y,
   input  logic [DATA_DEPTH-1:0] i_u,
   input  logic [DATA_DEPTH-1:0] i_v,
   output logic                  o_vsync,
   output logic                  o_hsync,
   output logic                  o_de,
   output logic [DATA_DEPTH-1:0] o_r,
   output logic [DATA_DEPTH-1:0] o_g,
   output logic [DATA_DEPTH-1:0] o_b,
   output logic                  o_csc_active
);
   localparam int D  = DATA_DEPTH;
   localparam int PW = D + 11;
   localparam int SW = D + 12;
   localparam logic VS_ACT = (VS_POLARITY == "POSITIVE");
   localparam logic HS_ACT = (HS_POLARITY == "POSITIVE");
   localparam logic signed [PW-1:0] K_RV = PW'(COEF_RV);
   localparam logic signed [PW-1:0] K_GU = PW'(COEF_GU);
   localparam logic signed [PW-1:0] K_GV = PW'(COEF_GV);
   localparam logic signed [PW-1:0] K_BU = PW'(COEF_BU);

   logic                 vs_d, r_csc_en, vs_edge, en1, en2;
   logic [2:0]           vs_p, hs_p, de_p;
   logic [D-1:0]         y1, u1, v1, y2, u2, v2;
   logic signed [D:0]    cu, cv, cu1, cv1;
   logic signed [PW-1:0] pr, pg, pb;
   logic signed [SW-1:0] ys, sr, sg, sb;

   function automatic logic [D-1:0] sat(input logic signed [SW-1:0] s);
      logic signed [SW-1:0] t;
      t = s >>> 8;
      return t[SW-1] ? '0 : (|t[SW-2:D]) ? '1 : t[D-1:0];
   endfunction

   assign vs_edge = (i_vsync == VS_ACT) && (vs_d != VS_ACT);
   assign cu = $signed({1'b0, i_u}) - $signed({2'b01, {(D-1){1'b0}}});
   assign cv = $signed({1'b0, i_v}) - $signed({2'b01, {(D-1){1'b0}}});
   assign ys = SW'($signed({1'b0, y2, 8'b0}));
   assign sr = ys + SW'(pr) + SW'(128);
   assign sg = ys - SW'(pg) + SW'(128);
   assign sb = ys + SW'(pb) + SW'(128);
   assign o_vsync = vs_p[2];
   assign o_hsync = hs_p[2];
   assign o_de = de_p[2];
   assign o_csc_active = r_csc_en;

   always_ff @(posedge i_pclk or posedge i_arst) begin
      if (i_arst) begin
         vs_d <= ~VS_ACT;
         r_csc_en <= 1'b0;
         vs_p <= {3{~VS_ACT}};
         hs_p <= {3{~HS_ACT}};
         de_p <= '0;
         en1 <= 1'b0;
         en2 <= 1'b0;
         {y1, u1, v1, y2, u2, v2} <= '0;
         cu1 <= '0;
         cv1 <= '0;
         {pr, pg, pb} <= '0;
         {o_r, o_g, o_b} <= '0;
      end else begin
         vs_d <= i_vsync;
         r_csc_en <= vs_edge ? i_csc_en : r_csc_en;
         vs_p <= {vs_p[1:0], i_vsync};
         hs_p <= {hs_p[1:0], i_hsync};
         de_p <= {de_p[1:0], i_de};
         // the pixel arriving with the vsync edge already uses the new mode
         en1 <= vs_edge ? i_csc_en : r_csc_en;
         y1 <= i_y;
         u1 <= i_u;
         v1 <= i_v;
         cu1 <= cu;
         cv1 <= cv;
         en2 <= en1;
         y2 <= y1;
         u2 <= u1;
         v2 <= v1;
         pr <= K_RV * PW'(cv1);
         pg <= K_GU * PW'(cu1) + K_GV * PW'(cv1);
         pb <= K_BU * PW'(cu1);
         o_r <= en2 ? sat(sr) : y2;
         o_g <= en2 ? sat(sg) : u2;
         o_b <= en2 ? sat(sb) : v2;
      end
   end
endmodule

// File: tb/tb_yuv2rgb_csc.sv
// tb_yuv2rgb_csc: scoreboard bench for yuv2rgb_csc, one instance per sync polarity.
module tb_yuv2rgb_csc;
   logic clk = 0, rst, en, vs, hs, de;
   logic [7:0] y, u, v;
   logic n_vs, n_hs, n_de, n_act, p_vs, p_hs, p_de, p_act;
   logic [7:0] n_r, n_g, n_b, p_r, p_g, p_b;
   int n_chk = 0, n_fail = 0;
   logic m_en, m_vs_d;

   typedef struct {logic vs, hs, de; logic [7:0] r, g, b;} exp_t;
   typedef struct {logic [7:0] y, u, v, r, g, b;} vec_t;
   exp_t q[$];
   exp_t me;
   vec_t tab[6];

   always #5 clk = ~clk;

   yuv2rgb_csc dn (.i_arst(rst), .i_pclk(clk), .i_csc_en(en), .i_vsync(vs), .i_hsync(hs),
      .i_de(de), .i_y(y), .i_u(u), .i_v(v), .o_vsync(n_vs), .o_hsync(n_hs), .o_de(n_de),
      .o_r(n_r), .o_g(n_g), .o_b(n_b), .o_csc_active(n_act));

   yuv2rgb_csc #(.HS_POLARITY("POSITIVE"), .VS_POLARITY("POSITIVE")) dp (.i_arst(rst),
      .i_pclk(clk), .i_csc_en(en), .i_vsync(vs), .i_hsync(hs), .i_de(de), .i_y(y), .i_u(u),
      .i_v(v), .o_vsync(p_vs), .o_hsync(p_hs), .o_de(p_de), .o_r(p_r), .o_g(p_g), .o_b(p_b),
      .o_csc_active(p_act));

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] clip(input int s);
      int t;
      t = s >>> 8;
      return t < 0 ? 8'd0 : t > 255 ? 8'd255 : 8'(t);
   endfunction

   task automatic rst_chk();
      chk("rst_n_vs", n_vs, 1); chk("rst_n_hs", n_hs, 1);
      chk("rst_p_vs", p_vs, 0); chk("rst_p_hs", p_hs, 0);
      chk("rst_n_de", n_de, 0); chk("rst_p_de", p_de, 0);
      chk("rst_n_rgb", {n_r, n_g, n_b}, 0); chk("rst_p_rgb", {p_r, p_g, p_b}, 0);
      chk("rst_n_act", n_act, 0); chk("rst_p_act", p_act, 0);
   endtask

   task automatic drive(input logic ien, ivs, ihs, ide, input logic [7:0] iy, iu, iv,
                        input logic ovr, input logic [7:0] er, eg, eb);
      exp_t e;
      logic pe;
      int yy, cu, cv;
      en = ien; vs = ivs; hs = ihs; de = ide; y = iy; u = iu; v = iv;
      pe = (!ivs && m_vs_d) ? ien : m_en;
      m_en = pe;
      m_vs_d = ivs;
      yy = int'(iy) * 256;
      cu = int'(iu) - 128;
      cv = int'(iv) - 128;
      e.vs = ivs; e.hs = ihs; e.de = ide;
      if (ovr) {e.r, e.g, e.b} = {er, eg, eb};
      else if (pe) begin
         e.r = clip(yy + 359 * cv + 128);
         e.g = clip(yy - 88 * cu - 183 * cv + 128);
         e.b = clip(yy + 454 * cu + 128);
      end else {e.r, e.g, e.b} = {iy, iu, iv};
      q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic rnd(input logic ren, input int n);
      for (int i = 0; i < n; i++)
         drive(ren ? 1'b1 : 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom), 0, 0, 0, 0);
   endtask

   always @(posedge clk) begin
      #1;
      if (!rst && q.size() == 3) begin
         me = q.pop_front();
         chk("n_vs", n_vs, me.vs); chk("n_hs", n_hs, me.hs); chk("n_de", n_de, me.de);
         chk("p_vs", p_vs, me.vs); chk("p_hs", p_hs, me.hs); chk("p_de", p_de, me.de);
         chk("r", n_r, me.r); chk("g", n_g, me.g); chk("b", n_b, me.b);
      end
   end

   initial begin
      tab[0] = '{128, 128, 128, 128, 128, 128};
      tab[1] = '{255, 128, 255, 255, 164, 255};
      tab[2] = '{0, 0, 0, 0, 136, 0};
      tab[3] = '{100, 50, 200, 201, 75, 0};
      tab[4] = '{200, 200, 50, 91, 231, 255};
      tab[5] = '{16, 128, 128, 16, 16, 16};
      rst = 1; en = 1; vs = 1; hs = 1; de = 0; y = 0; u = 0; v = 0;
      m_en = 0; m_vs_d = 1;
      repeat (2) @(posedge clk);
      #2;
      rst_chk();
      rst = 0;
      repeat (2) drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("act_latch_on", n_act, 1);
      drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++)
         drive(1, 1, 1, 1, tab[i].y, tab[i].u, tab[i].v, 1, tab[i].r, tab[i].g, tab[i].b);
      rnd(1, 40);
      drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) drive(0, 1, 1, 1, 10, 20, 30, 1, 0, 117, 0);
      chk("act_hold_mid", n_act, 1);
      drive(0, 0, 1, 1, 10, 20, 30, 1, 10, 20, 30);
      chk("act_latch_off", n_act, 0);
      drive(1, 0, 1, 1, 10, 20, 30, 1, 10, 20, 30);
      repeat (2) drive(1, 1, 1, 1, 10, 20, 30, 1, 10, 20, 30);
      chk("act_hold_off", n_act, 0);
      drive(1, 0, 1, 1, 255, 128, 255, 1, 255, 164, 255);
      chk("act_relatch", n_act, 1);
      rnd(0, 200);
      drive(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      rnd(1, 3);
      rst = 1;
      #1;
      rst_chk();
      q.delete();
      m_en = 0; m_vs_d = 1;
      @(posedge clk);
      #2;
      rst_chk();
      rst = 0;
      drive(0, 1, 1, 1, 5, 6, 7, 1, 5, 6, 7);
      chk("post_rst_de1", n_de, 0);
      drive(0, 1, 1, 1, 8, 9, 10, 1, 8, 9, 10);
      chk("post_rst_de2", n_de, 0);
      repeat (4) drive(0, 1, 1, 0, 1, 2, 3, 1, 1, 2, 3);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/yuv2rgb_csc.md
Name: yuv2rgb_csc

Overview:
- Colour-space converter that sits directly downstream of the posterize stage in the v_filter video pipeline.
- Converts the 8-bit YUV 4:4:4 pixel stream (full-range BT.601) back to RGB888 for the display/HDMI output path.
- Fixed-latency 3-stage pipeline; the sync and DE signals are delayed by the same amount.
- The enable bypass is applied only at frame boundaries, so a frame is never partially converted.

Parameters:
- DATA_DEPTH, 8, width of each Y/U/V input and each R/G/B output.
- HS_POLARITY, "NEGATIVE", active level of hsync ("NEGATIVE" or "POSITIVE").
- VS_POLARITY, "NEGATIVE", active level of vsync ("NEGATIVE" or "POSITIVE").
- COEF_RV, 359, V-to-R coefficient ×256.
- COEF_GU, 88, U-to-G coefficient ×256 (subtracted).
- COEF_GV, 183, V-to-G coefficient ×256 (subtracted).
- COEF_BU, 454, U-to-B coefficient ×256.

Ports:
- i_arst  in  1  asynchronous reset, active-high
- i_pclk  in  1  pixel clock
- i_csc_en  in  1  1 = convert; 0 = bypass (R=Y, G=U, B=V); applied per frame
- i_vsync  in  1  vertical sync
- i_hsync  in  1  horizontal sync
- i_de  in  1  data enable
- i_y  in  DATA_DEPTH  luma
- i_u  in  DATA_DEPTH  Cb
- i_v  in  DATA_DEPTH  Cr
- o_vsync  out  1  vsync delayed 3 cycles
- o_hsync  out  1  hsync delayed 3 cycles
- o_de  out  1  DE delayed 3 cycles
- o_r  out  DATA_DEPTH  red
- o_g  out  DATA_DEPTH  green
- o_b  out  DATA_DEPTH  blue
- o_csc_active  out  1  currently latched per-frame enable

Behaviour:

Reset:
- All pipeline registers cleared.
- o_vsync/o_hsync take their inactive level; o_de=0; o_r/o_g/o_b=0; o_csc_active=0.
- Reset asserted mid-frame clears the pipeline immediately. Output resumes 3 cycles after the first post-reset input.

Latency and timing:
- Exactly 3 cycles from every input (sync, DE, data) to output.
- Throughput 1 pixel per clock; no back-pressure.
- Data is converted on every cycle regardless of DE. Blanking data passes through converted; downstream qualifies with o_de.

Enable latch:
- r_csc_en is loaded from i_csc_en on the cycle i_vsync transitions inactive→active (edge detected against its 1-cycle-delayed copy).
- At all other times r_csc_en holds.
- o_csc_active = r_csc_en.
- The latched value travels down the pipeline with the pixel data, so the mode switch aligns exactly with the delayed o_vsync edge.

Stage 1 (offset removal):
- cu = i_u − 2^(DATA_DEPTH−1), cv = i_v − 2^(DATA_DEPTH−1), both signed DATA_DEPTH+1 bits.
- Register y, cu, cv, the raw u/v (for bypass), syncs, DE, and the enable.

Stage 2 (products, signed, DATA_DEPTH+11 bits):
- pr = COEF_RV·cv
- pg = COEF_GU·cu + COEF_GV·cv
- pb = COEF_BU·cu
- Also register y<<8.

Stage 3 (sum, shift, saturate):
- sR = (y<<8) + pr + 128
- sG = (y<<8) − pg + 128
- sB = (y<<8) + pb + 128
- Arithmetic shift right by 8 (floor).
- Saturate: result < 0 → 0; result > 2^DATA_DEPTH−1 → all ones.
- If the stage-3 enable is 0, output R=Y, G=U, B=V unmodified.

Simultaneous events:
- vsync edge coincides with an i_csc_en change: the new value is captured.
- i_csc_en toggling mid-frame has no effect until the next vsync edge.

Sync polarity:
- Edge detection uses VS_POLARITY.
- HS_POLARITY is used only for the reset level of o_hsync.

Test Plan:
1. Reset, then drive en=1 with a vsync edge; input Y=128,U=128,V=128 with DE=1 → 3 cycles later R=G=B=128, o_de=1.
2. en=1; input Y=255,U=128,V=255 → R=255 (saturated from 433), G=164, B=255.
3. en=1; input Y=0,U=0,V=0 → R=0 (from −179), G=136, B=0 (from −227). Confirms negative clamp and floor shift.
4. en=1 frame running; set i_csc_en=0 mid-frame → output stays converted until the next vsync active edge. From the pixel aligned with that edge onward, R=Y, G=U, B=V (e.g. Y=10,U=20,V=30 → 10,20,30); o_csc_active falls on the latch cycle.
5. Random hsync/vsync/DE pattern with VS_POLARITY/HS_POLARITY both "NEGATIVE" and both "POSITIVE" → o_* sync/DE equal the inputs delayed exactly 3 cycles; reset levels match polarity.
6. Assert i_arst mid-line with DE=1 → outputs immediately show inactive sync, DE=0, RGB=0. After release, first valid pixel appears 3 cycles after the first input.
